histogram_eq_param: RTL and testbench

Parametrised histogram-equalisation engine: builds a per-frame histogram of a pixel stream in an external single-port-read/single-port-write SRAM, optionally clips bin counts (contrast limit), and streams a 2^PIXEL_BIT-entry mapping LUT for the downstream pixel remapper. Successor to the fixed 8-bit histogram/equalisation pair; adds width parametrisation, clip limit, read-modify-write forwarding, abort/restart and a degenerate-frame rule.

---
 rtl/histogram_eq_param.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_histogram_eq_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/histogram_eq_param.sv
// Histogram-equalisation engine. It builds a per-frame histogram in an
// external SRAM and can clip bins to a contrast limit. It then streams a
// 2^PIXEL_BIT-entry remapping LUT, computing each entry with a sequential
// restoring divider.
module histogram_eq_param #(
    parameter int PIXEL_BIT = 8,
    parameter int COUNT_BIT = 17
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 pixel_valid_i,
    input  logic [PIXEL_BIT-1:0] pixel_i,
    input  logic                 frame_end_i,
    input  logic [COUNT_BIT-1:0] clip_i,
    input  logic                 stall_i,
    output logic                 pixel_ready_o,
    output logic                 busy_o,
    output logic                 wr_en_o,
    output logic [PIXEL_BIT-1:0] wr_addr_o,
    output logic [COUNT_BIT-1:0] wr_data_o,
    output logic                 rd_en_o,
    output logic [PIXEL_BIT-1:0] rd_addr_o,
    input  logic [COUNT_BIT-1:0] rd_data_i,
    output logic                 lut_valid_o,
    output logic [PIXEL_BIT-1:0] lut_addr_o,
    output logic [PIXEL_BIT-1:0] lut_data_o,
    output logic                 done_o
);
    localparam int NUM_BIT = COUNT_BIT + PIXEL_BIT;
    localparam int PH_BIT  = $clog2(NUM_BIT + 2);
    localparam logic [PH_BIT-1:0]    PH_LOAD = PH_BIT'(1);
    localparam logic [PH_BIT-1:0]    PH_LAST = PH_BIT'(NUM_BIT + 1);
    localparam logic [PIXEL_BIT-1:0] MAXV    = '1;
    localparam logic [COUNT_BIT-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_SUM, S_MAP, S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic [PIXEL_BIT:0]   r_idx;        // bin index; extra bit lets SUM reach BINS
    logic [PH_BIT-1:0]    r_phase;      // per-bin step inside MAP
    logic                 r_p1_valid;   // a read was issued in the previous active cycle
    logic [PIXEL_BIT-1:0] r_p1_addr;
    logic                 r_rd_last;    // a read was issued in the previous clock
    logic                 r_hold_valid;
    logic [COUNT_BIT-1:0] r_hold_data;
    logic                 r_fwd_valid;  // histogram write of the previous active cycle
    logic [PIXEL_BIT-1:0] r_fwd_addr;
    logic [COUNT_BIT-1:0] r_fwd_data;
    logic [COUNT_BIT-1:0] r_total;
    logic [COUNT_BIT-1:0] r_clip;
    logic [COUNT_BIT-1:0] r_sum;
    logic [COUNT_BIT-1:0] r_cdf_min;
    logic                 r_min_found;
    logic [COUNT_BIT-1:0] r_cdf;
    logic                 r_lut_zero;
    logic [NUM_BIT-1:0]   r_div_q;
    logic [COUNT_BIT-1:0] r_div_r;

    logic                 w_active;
    logic                 w_idx_max;
    logic [COUNT_BIT-1:0] w_rd_val;
    logic [COUNT_BIT-1:0] w_base;
    logic [COUNT_BIT-1:0] w_inc;
    logic [COUNT_BIT-1:0] w_clipped;
    logic [COUNT_BIT-1:0] w_cdf_next;
    logic [COUNT_BIT-1:0] w_diff;
    logic [NUM_BIT-1:0]   w_num;
    logic [COUNT_BIT-1:0] w_den;
    logic                 w_den_zero;
    logic [COUNT_BIT:0]   w_trial;
    logic                 w_ge;
    logic [COUNT_BIT-1:0] w_r_next;
    logic [NUM_BIT-1:0]   w_q_next;
    logic [PIXEL_BIT-1:0] w_lut;

    // A start pulse aborts whatever is running, so it also suppresses the cycle's actions.
    assign w_active  = !stall_i && !start_i;
    assign w_idx_max = (r_idx[PIXEL_BIT-1:0] == MAXV);

    // Read data that arrived during a stall is taken from the holding register.
    assign w_rd_val  = r_hold_valid ? r_hold_data : rd_data_i;

    // The read was issued in the same cycle the previous write landed, so it holds
    // the stale count for the same bin; the in-flight value is used instead.
    assign w_base    = (r_fwd_valid && (r_fwd_addr == r_p1_addr)) ? r_fwd_data : w_rd_val;
    assign w_inc     = (w_base == CNT_MAX) ? w_base : w_base + COUNT_BIT'(1);

    assign w_clipped  = ((r_clip != '0) && (w_rd_val > r_clip)) ? r_clip : w_rd_val;
    assign w_cdf_next = r_cdf + w_clipped;
    assign w_diff     = w_cdf_next - r_cdf_min;
    assign w_num      = NUM_BIT'(w_diff) * NUM_BIT'(MAXV);
    assign w_den      = r_sum - r_cdf_min;
    assign w_den_zero = (w_den == '0);

    // One restoring-division step: shift in the next numerator bit, subtract if it fits.
    assign w_trial  = {r_div_r, r_div_q[NUM_BIT-1]};
    assign w_ge     = (w_trial >= {1'b0, w_den});
    assign w_r_next = w_ge ? (w_trial[COUNT_BIT-1:0] - w_den) : w_trial[COUNT_BIT-1:0];
    assign w_q_next = {r_div_q[NUM_BIT-2:0], w_ge};

    // Final LUT value; the last divider step is folded in combinationally.
    always_comb begin
        w_lut = '0;
        if (w_den_zero)
            w_lut = r_idx[PIXEL_BIT-1:0];
        else if (r_lut_zero)
            w_lut = '0;
        else if (w_q_next > NUM_BIT'(MAXV))
            w_lut = MAXV;
        else
            w_lut = w_q_next[PIXEL_BIT-1:0];
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic and SRAM / LUT port decode.
    always_comb begin
        w_state_next  = r_state;
        pixel_ready_o = 1'b0;
        busy_o        = (r_state != S_IDLE);
        wr_en_o       = 1'b0;
        wr_addr_o     = '0;
        wr_data_o     = '0;
        rd_en_o       = 1'b0;
        rd_addr_o     = '0;
        lut_valid_o   = 1'b0;
        lut_addr_o    = '0;
        lut_data_o    = '0;
        done_o        = 1'b0;
        case (r_state)
            S_CLEAR: begin
                wr_en_o   = w_active;
                wr_addr_o = r_idx[PIXEL_BIT-1:0];
                if (w_active && w_idx_max)
                    w_state_next = S_ACCUM;
            end
            S_ACCUM: begin
                pixel_ready_o = w_active;
                rd_en_o       = w_active && pixel_valid_i;
                rd_addr_o     = pixel_i;
                wr_en_o       = w_active && r_p1_valid;
                wr_addr_o     = r_p1_addr;
                wr_data_o     = w_inc;
                if (w_active && frame_end_i)
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                wr_en_o   = w_active && r_p1_valid;
                wr_addr_o = r_p1_addr;
                wr_data_o = w_inc;
                if (w_active)
                    w_state_next = S_SUM;
            end
            S_SUM: begin
                rd_en_o   = w_active && !r_idx[PIXEL_BIT];
                rd_addr_o = r_idx[PIXEL_BIT-1:0];
                if (w_active && r_idx[PIXEL_BIT])
                    w_state_next = S_MAP;
            end
            S_MAP: begin
                rd_en_o    = w_active && (r_phase == '0);
                rd_addr_o  = r_idx[PIXEL_BIT-1:0];
                if (r_phase == PH_LAST) begin
                    lut_valid_o = w_active;
                    lut_addr_o  = r_idx[PIXEL_BIT-1:0];
                    lut_data_o  = w_lut;
                    if (w_active && w_idx_max)
                        w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_o = w_active;
                if (w_active)
                    w_state_next = S_IDLE;
            end
            default: ;
        endcase
        if (start_i)
            w_state_next = S_CLEAR;
    end

    // Datapath: counters, read pipeline, forwarding, SUM accumulation and divider.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx        <= '0;
            r_phase      <= '0;
            r_p1_valid   <= 1'b0;
            r_p1_addr    <= '0;
            r_rd_last    <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_fwd_valid  <= 1'b0;
            r_fwd_addr   <= '0;
            r_fwd_data   <= '0;
            r_total      <= '0;
            r_clip       <= '0;
            r_sum        <= '0;
            r_cdf_min    <= '0;
            r_min_found  <= 1'b0;
            r_cdf        <= '0;
            r_lut_zero   <= 1'b0;
            r_div_q      <= '0;
            r_div_r      <= '0;
        end else begin
            r_rd_last <= rd_en_o;
            if (start_i) begin
                r_idx        <= '0;
                r_phase      <= '0;
                r_p1_valid   <= 1'b0;
                r_hold_valid <= 1'b0;
                r_fwd_valid  <= 1'b0;
                r_total      <= '0;
            end else if (stall_i) begin
                if (r_rd_last) begin
                    r_hold_data  <= rd_data_i;
                    r_hold_valid <= 1'b1;
                end
            end else begin
                r_hold_valid <= 1'b0;
                r_p1_valid   <= rd_en_o;
                r_p1_addr    <= rd_addr_o;
                r_fwd_valid  <= wr_en_o && ((r_state == S_ACCUM) || (r_state == S_DRAIN));
                r_fwd_addr   <= wr_addr_o;
                r_fwd_data   <= wr_data_o;
                case (r_state)
                    S_CLEAR: begin
                        r_total <= '0;
                        r_idx   <= w_idx_max ? '0 : r_idx + 1'b1;
                    end
                    S_ACCUM: begin
                        if (rd_en_o && (r_total != CNT_MAX))
                            r_total <= r_total + COUNT_BIT'(1);
                        if (frame_end_i)
                            r_clip <= clip_i;
                    end
                    S_DRAIN: begin
                        r_idx       <= '0;
                        r_sum       <= '0;
                        r_cdf_min   <= '0;
                        r_min_found <= 1'b0;
                    end
                    S_SUM: begin
                        if (r_p1_valid) begin
                            r_sum <= r_sum + w_clipped;
                            if (!r_min_found && (w_clipped != '0)) begin
                                r_cdf_min   <= w_clipped;
                                r_min_found <= 1'b1;
                            end
                        end
                        if (r_idx[PIXEL_BIT]) begin
                            r_idx   <= '0;
                            r_phase <= '0;
                            r_cdf   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    S_MAP: begin
                        if (r_phase == PH_LOAD) begin
                            r_cdf      <= w_cdf_next;
                            r_lut_zero <= (w_cdf_next < r_cdf_min) || (w_cdf_next == '0);
                            r_div_q    <= w_num;
                            r_div_r    <= '0;
                        end else if ((r_phase != '0) && (r_phase != PH_LAST)) begin
                            r_div_q <= w_q_next;
                            r_div_r <= w_r_next;
                        end
                        if (r_phase == PH_LAST) begin
                            r_phase <= '0;
                            r_idx   <= r_idx + 1'b1;
                        end else begin
                            r_phase <= r_phase + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_histogram_eq_param.sv
// Bench for histogram_eq_param: SRAM model, frame driver, LUT capture and a
// reference equaliser computed directly from the pixel list.
module tb_histogram_eq_param;
    localparam int PB   = 8;
    localparam int CB   = 17;
    localparam int BINS = 1 << PB;

    logic          clk = 1'b0;
    logic          rst, start, pv, fe, stall;
    logic [PB-1:0] px;
    logic [CB-1:0] clip, rd_data;
    logic          pixel_ready, busy, wr_en, rd_en, lut_valid, done;
    logic [PB-1:0] wr_addr, rd_addr, lut_addr, lut_data;
    logic [CB-1:0] wr_data;

    logic [CB-1:0] mem [BINS];
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int lut_addr_q[$];
    int lut_data_q[$];
    int ref_lut[BINS];

    always #5 clk = ~clk;

    histogram_eq_param #(.PIXEL_BIT(PB), .COUNT_BIT(CB)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pixel_valid_i(pv),
        .pixel_i(px), .frame_end_i(fe), .clip_i(clip), .stall_i(stall),
        .pixel_ready_o(pixel_ready), .busy_o(busy),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .lut_valid_o(lut_valid), .lut_addr_o(lut_addr), .lut_data_o(lut_data),
        .done_o(done)
    );

    // External SRAM: read data is only meaningful the cycle after rd_en.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= CB'($urandom);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Capture the LUT stream and make sure the block is silent while stalled.
    always @(negedge clk) begin
        if (lut_valid) begin
            lut_addr_q.push_back(int'(lut_addr));
            lut_data_q.push_back(int'(lut_data));
        end
        if (done) done_cnt++;
        if (stall) chk("stall_quiet", {wr_en, rd_en, lut_valid, done}, 0);
    end

    // Reference equaliser from the pixel list and clip limit.
    task automatic build_ref(input int pix[$], input int clip_v);
        longint cnt[BINS];
        longint c[BINS];
        longint tot, cmin, den, cdf, v;
        foreach (cnt[i]) cnt[i] = 0;
        foreach (pix[k]) cnt[pix[k]]++;
        tot = 0; cmin = 0;
        for (int i = 0; i < BINS; i++) begin
            c[i] = (clip_v != 0 && cnt[i] > clip_v) ? longint'(clip_v) : cnt[i];
            tot += c[i];
            if (cmin == 0) cmin = c[i];
        end
        den = tot - cmin;
        cdf = 0;
        for (int i = 0; i < BINS; i++) begin
            cdf += c[i];
            if (den == 0)                   v = i;
            else if (cdf == 0 || cdf < cmin) v = 0;
            else begin
                v = ((cdf - cmin) * (BINS - 1)) / den;
                if (v > BINS - 1) v = BINS - 1;
            end
            ref_lut[i] = int'(v);
        end
    endtask

    function automatic int got_lut(input int i);
        return (i < lut_data_q.size()) ? lut_data_q[i] : -1;
    endfunction

    // Drive one frame and collect its LUT; optionally leave mid-MAP after abort_at entries.
    task automatic run_frame(input string name, input int pix[$], input int clip_v,
                             input int pct, input int abort_at);
        int idx, budget;
        bit seen;
        lut_addr_q.delete();
        lut_data_q.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; stall = 1'b0; pv = 1'b0; fe = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; budget = 0;
        while (idx < pix.size() && budget < 20000) begin
            stall = ($urandom_range(0, 99) < pct);
            pv    = 1'b1;
            px    = PB'(pix[idx]);
            fe    = (idx == pix.size() - 1);
            clip  = fe ? CB'(clip_v) : CB'($urandom);
            @(negedge clk);
            if (pixel_ready) idx++;
            @(posedge clk); #1;
            budget++;
        end
        chk({name, " pixels_accepted"}, idx, pix.size());
        pv = 1'b0; fe = 1'b0; clip = CB'($urandom);
        seen = 1'b0; budget = 0;
        while (budget < 40000) begin
            stall = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            if (abort_at > 0 && lut_data_q.size() >= abort_at) break;
            @(posedge clk); #1;
            budget++;
        end
        stall = 1'b0;
        if (abort_at > 0) begin
            chk({name, " busy_mid_map"}, busy, 1);
            chk({name, " abort_no_done"}, done_cnt, 0);
            return;
        end
        chk({name, " done_seen"}, seen, 1);
        repeat (3) @(posedge clk);
        #1;
        chk({name, " done_once"}, done_cnt, 1);
        chk({name, " busy_after"}, busy, 0);
        chk({name, " lut_count"}, lut_data_q.size(), BINS);
        build_ref(pix, clip_v);
        for (int i = 0; i < BINS; i++) begin
            chk($sformatf("%s lut_addr[%0d]", name, i),
                (i < lut_addr_q.size()) ? lut_addr_q[i] : -1, i);
            chk($sformatf("%s lut[%0d]", name, i), got_lut(i), ref_lut[i]);
        end
    endtask

    initial begin
        int q[$];
        int cl;
        rst = 1'b1; start = 1'b0; pv = 1'b0; fe = 1'b0; stall = 1'b0;
        px = '0; clip = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_outputs", {pixel_ready, busy, wr_en, wr_addr, wr_data, rd_en, rd_addr,
                            lut_valid, lut_addr, lut_data, done}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        q.delete();
        for (int i = 0; i < BINS; i++) q.push_back(i);
        run_frame("ramp", q, 0, 0, 0);

        q.delete();
        repeat (100) q.push_back(10);
        repeat (100) q.push_back(200);
        run_frame("two_val", q, 0, 0, 0);

        q.delete();
        repeat (50) q.push_back(77);
        run_frame("single", q, 0, 0, 0);

        q.delete();
        repeat (10) q.push_back(5);
        repeat (10) q.push_back(6);
        repeat (1000) q.push_back(7);
        run_frame("fwd", q, 0, 0, 0);
        chk("sram_bin7", mem[7], 1000);
        chk("sram_bin6", mem[6], 10);
        chk("fwd lut6_const", got_lut(6), 2);

        run_frame("fwd_clip", q, 10, 0, 0);
        chk("clip lut5_const", got_lut(5), 0);
        chk("clip lut6_const", got_lut(6), 127);
        chk("clip lut7_const", got_lut(7), 255);

        q.delete();
        for (int i = 0; i < BINS; i++) q.push_back(i);
        run_frame("ramp_stall", q, 0, 30, 0);

        q.delete();
        repeat (100) q.push_back(10);
        repeat (100) q.push_back(200);
        run_frame("abort", q, 0, 0, 20);
        run_frame("after_abort", q, 0, 0, 0);

        q.delete();
        q.push_back($urandom_range(0, BINS - 1));
        repeat ($urandom_range(20, 400)) begin
            if ($urandom_range(0, 1) == 1) q.push_back(q[q.size() - 1]);
            else                           q.push_back($urandom_range(0, BINS - 1));
        end
        cl = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 30);
        run_frame("random", q, cl, 10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
